// File: rtl/sdp_ram_pkg.sv
// Shared types and helpers for the sdp_ram_ctrl block: clear-sequencer state
// encoding, read-during-write policy constants, byte merge and parity helpers.
// Helpers work on a fixed maximum width (MAX_DATA_W). Callers size-cast their
// operands in and the result back out, so any DATA_W up to MAX_DATA_W works.
package sdp_ram_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  localparam int MAX_DATA_W = 256;
  localparam int MAX_BYTES  = MAX_DATA_W / 8;

  // Replace the bytes of old_w selected by be with the same bytes of new_w.
  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_w,
    input logic [MAX_DATA_W-1:0] new_w,
    input logic [MAX_BYTES-1:0]  be
  );
    logic [MAX_DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  // Even parity bit per byte: each bit makes its byte plus parity hold an even number of ones.
  function automatic logic [MAX_BYTES-1:0] byte_parity(input logic [MAX_DATA_W-1:0] word);
    logic [MAX_BYTES-1:0] p;
    for (int i = 0; i < MAX_BYTES; i++) begin
      p[i] = ^word[8*i +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/sdp_ram_ctrl_if.sv
// Bus bundle between a memory user (master) and sdp_ram_ctrl (slave).
//
// Handshake semantics: there is no ready/backpressure. A write is taken on any
// rising edge where we=1 and clr_busy=0. A read is taken on any rising edge
// where re=1 and clr_busy=0. Each taken read returns exactly one rvalid pulse
// READ_LAT cycles later, with rdata and perr qualified by that pulse. Requests
// made while clr_busy=1 are discarded. clr_req is a one-cycle pulse that only
// starts a sweep when clr_busy=0.
interface sdp_ram_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13
);
  logic                clr_req;
  logic                clr_busy;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wbe;
  logic                re;
  logic [ADDR_W-1:0]   raddr;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;
  logic                perr;

  modport master (
    output clr_req, we, waddr, wdata, wbe, re, raddr,
    input  clr_busy, rdata, rvalid, perr
  );

  modport slave (
    input  clr_req, we, waddr, wdata, wbe, re, raddr,
    output clr_busy, rdata, rvalid, perr
  );
endinterface

// File: rtl/sdp_ram_array.sv
// Inferred simple dual-port storage. Each lane (byte, or byte plus parity bit)
// is kept in its own array so it maps onto block RAM with per-lane write
// enables. The read is registered and read-first: a same-address write in the
// same cycle is not visible until the next read. There is no reset, so this
// stays a plain RAM.
module sdp_ram_array #(
  parameter int LANE_W = 8,
  parameter int LANES  = 2,
  parameter int DEPTH  = 8192,
  parameter int ADDR_W = 13
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [LANES*LANE_W-1:0] wdata,
  input  logic [LANES-1:0]        be,
  input  logic                    re,
  input  logic [ADDR_W-1:0]       raddr,
  output logic [LANES*LANE_W-1:0] rdata
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_W-1:0] mem [DEPTH];
    logic [LANE_W-1:0] q;

    // Per-lane write with lane enable; registered read returns the pre-write word.
    always_ff @(posedge clk) begin
      if (we && be[i]) mem[waddr] <= wdata[i*LANE_W +: LANE_W];
      if (re) q <= mem[raddr];
    end

    assign rdata[i*LANE_W +: LANE_W] = q;
  end

endmodule

// File: rtl/sdp_ram_ctrl.sv
// Parametrised simple dual-port RAM controller: a byte-enable write port, a
// read port with a valid strobe, selectable read latency (1 or 2), a
// read-during-write policy, and a clear/fill sweep sequencer.
// Optional feature macro: SDP_RAM_PARITY_EN. When it is defined, each stored
// byte carries an even-parity bit and perr flags mismatches on read. When it
// is undefined, perr is tied low.
// DATA_W must be a multiple of 8 and no larger than sdp_ram_pkg::MAX_DATA_W.
module sdp_ram_ctrl
  import sdp_ram_pkg::*;
#(
  parameter int                DATA_W         = 16,
  parameter int                DEPTH          = 8192,
  parameter int                ADDR_W         = $clog2(DEPTH),
  parameter int                READ_LAT       = 1,
  parameter int                RDW_MODE       = RDW_READ_FIRST,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] FILL           = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  sdp_ram_ctrl_if.slave bus,
  output clr_state_t   dbg_state
);

  localparam int NB = DATA_W / 8;
`ifdef SDP_RAM_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif
  localparam int MEM_W = NB * LANE_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Place each data byte in its lane. With parity enabled, the lane's top bit holds that byte's parity.
  function automatic logic [MEM_W-1:0] pack_word(input logic [DATA_W-1:0] d);
    logic [MEM_W-1:0] w;
`ifdef SDP_RAM_PARITY_EN
    logic [MAX_BYTES-1:0] p;
    p = byte_parity(MAX_DATA_W'(d));
`endif
    w = '0;
    for (int i = 0; i < NB; i++) begin
`ifdef SDP_RAM_PARITY_EN
      w[i*LANE_W +: LANE_W] = {p[i], d[8*i +: 8]};
`else
      w[i*LANE_W +: LANE_W] = d[8*i +: 8];
`endif
    end
    return w;
  endfunction

  clr_state_t        state;
  logic [ADDR_W-1:0] cnt;
  logic              clr_busy_q;

  logic              w_in_range;
  logic              r_in_range;
  logic              user_we;
  logic              user_re;

  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [MEM_W-1:0]  arr_wdata;
  logic [NB-1:0]     arr_be;
  logic [MEM_W-1:0]  arr_rdata;

  // Stage-1 read context. It is captured only when a read is taken, so the result below holds between reads.
  logic              rv1;
  logic              have1;
  logic              oor1;
  logic              byp1;
  logic [DATA_W-1:0] byp_data1;
  logic [NB-1:0]     byp_be1;

  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] res_data;
  logic              res_perr;

  // Out-of-range is judged against DEPTH, which need not be a power of two.
  assign w_in_range = int'(bus.waddr) < DEPTH;
  assign r_in_range = int'(bus.raddr) < DEPTH;
  assign user_we    = bus.we & ~clr_busy_q & w_in_range;
  assign user_re    = bus.re & ~clr_busy_q;

  assign bus.clr_busy = clr_busy_q;
  assign dbg_state    = state;

  // Clear sequencer: sweep FILL over every address once, with one write per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt        <= '0;
      clr_busy_q <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state      <= CLEAR;
            cnt        <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt == LAST_ADDR) begin
            state      <= IDLE;
            cnt        <= '0;
            clr_busy_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Write-port mux: the sweep owns the write port while it runs.
  always_comb begin
    arr_we    = user_we;
    arr_waddr = bus.waddr;
    arr_wdata = pack_word(bus.wdata);
    arr_be    = bus.wbe;
    if (state == CLEAR) begin
      arr_we    = 1'b1;
      arr_waddr = cnt;
      arr_wdata = pack_word(FILL);
      arr_be    = '1;
    end
  end

  sdp_ram_array #(
    .LANE_W (LANE_W),
    .LANES  (NB),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .be    (arr_be),
    .re    (user_re & r_in_range),
    .raddr (bus.raddr),
    .rdata (arr_rdata)
  );

  // Capture per-read context alongside the array's registered read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rv1       <= 1'b0;
      have1     <= 1'b0;
      oor1      <= 1'b0;
      byp1      <= 1'b0;
      byp_data1 <= '0;
      byp_be1   <= '0;
    end else begin
      rv1 <= user_re;
      if (user_re) begin
        have1     <= 1'b1;
        oor1      <= ~r_in_range;
        byp1      <= (RDW_MODE == RDW_WRITE_FIRST) && user_we && (bus.waddr == bus.raddr);
        byp_data1 <= bus.wdata;
        byp_be1   <= bus.wbe;
      end
    end
  end

  // Unpack the data bytes from the array's lanes.
  always_comb begin
    rd_data1 = '0;
    for (int i = 0; i < NB; i++) begin
      rd_data1[8*i +: 8] = arr_rdata[i*LANE_W +: 8];
    end
  end

  // Select the read result: zero before any read and for out-of-range reads, else stored or bypass-merged data.
  always_comb begin
    res_data = rd_data1;
    if (!have1 || oor1) begin
      res_data = '0;
    end else if (byp1) begin
      res_data = DATA_W'(byte_merge(MAX_DATA_W'(rd_data1), MAX_DATA_W'(byp_data1), MAX_BYTES'(byp_be1)));
    end
  end

`ifdef SDP_RAM_PARITY_EN
  logic [NB-1:0] rd_par1;
  logic [NB-1:0] par_err;

  // Compare stored parity with recomputed parity. Bytes replaced by the bypass are fresh and cannot be in error.
  always_comb begin
    rd_par1 = '0;
    for (int i = 0; i < NB; i++) begin
      rd_par1[i] = arr_rdata[i*LANE_W + 8];
    end
    par_err = (rd_par1 ^ NB'(byte_parity(MAX_DATA_W'(rd_data1)))) & ~(byp1 ? byp_be1 : '0);
  end

  assign res_perr = have1 & ~oor1 & (|par_err);
`else
  assign res_perr = 1'b0;
`endif

  if (READ_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              perr_q;

    // Extra output register. rdata only loads on a valid read, so it holds otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
        perr_q   <= 1'b0;
      end else begin
        rvalid_q <= rv1;
        perr_q   <= rv1 & res_perr;
        if (rv1) rdata_q <= res_data;
      end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.perr   = perr_q;
  end else begin : g_lat1
    assign bus.rdata  = res_data;
    assign bus.rvalid = rv1;
    assign bus.perr   = rv1 & res_perr;
  end

endmodule

// File: tb/tb_sdp_ram_ctrl.sv
// Bench for sdp_ram_ctrl. Two instances share one stimulus stream:
//   a: DEPTH=16, READ_LAT=1, read-first,  clear on reset, FILL=A5A5
//   b: DEPTH=12, READ_LAT=2, write-first, no clear on reset, FILL=5A3C
// Each instance has a behavioural model: a word array updated with the
// write/clear rules, a countdown of remaining sweep cycles, and a scoreboard
// queue of expected read words tagged with their due cycle.
module tb_sdp_ram_ctrl;
  import sdp_ram_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        we;
  logic        re;
  logic        clr_req;
  logic [3:0]  waddr;
  logic [3:0]  raddr;
  logic [15:0] wdata;
  logic [1:0]  wbe;
  clr_state_t  dbg_a;
  clr_state_t  dbg_b;

  sdp_ram_ctrl_if #(.DATA_W(16), .ADDR_W(4)) bus_a ();
  sdp_ram_ctrl_if #(.DATA_W(16), .ADDR_W(4)) bus_b ();

  assign bus_a.clr_req = clr_req;
  assign bus_a.we      = we;
  assign bus_a.waddr   = waddr;
  assign bus_a.wdata   = wdata;
  assign bus_a.wbe     = wbe;
  assign bus_a.re      = re;
  assign bus_a.raddr   = raddr;
  assign bus_b.clr_req = clr_req;
  assign bus_b.we      = we;
  assign bus_b.waddr   = waddr;
  assign bus_b.wdata   = wdata;
  assign bus_b.wbe     = wbe;
  assign bus_b.re      = re;
  assign bus_b.raddr   = raddr;

  sdp_ram_ctrl #(
    .DATA_W(16), .DEPTH(16), .READ_LAT(1), .RDW_MODE(0),
    .CLEAR_ON_RESET(1), .FILL(16'hA5A5)
  ) u_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .dbg_state(dbg_a)
  );

  sdp_ram_ctrl #(
    .DATA_W(16), .DEPTH(12), .READ_LAT(2), .RDW_MODE(1),
    .CLEAR_ON_RESET(0), .FILL(16'h5A3C)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b), .dbg_state(dbg_b)
  );

  // Per-instance configuration as seen by the model
  int          depth_c [2] = '{16, 12};
  int          lat_c   [2] = '{1, 2};
  int          rdw_c   [2] = '{0, 1};
  int          cor_c   [2] = '{1, 0};
  logic [15:0] fill_c  [2] = '{16'hA5A5, 16'h5A3C};

  // Model state
  logic [15:0] mem_m     [2][16];
  logic        corrupt_m [2][16];
  int          rem_m     [2];
  logic [15:0] last_m    [2];
  logic [16:0] exp_q0 [$];
  logic [16:0] exp_q1 [$];
  int          due_q0 [$];
  int          due_q1 [$];
  int          cyc;
  logic        perr_seen_a;

  int checks;
  int failures;

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] merge16(input logic [15:0] o, input logic [15:0] n, input logic [1:0] be);
    logic [15:0] m;
    m = {{8{be[1]}}, {8{be[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  task automatic push_exp(input int d, input logic [16:0] item, input int due);
    if (d == 0) begin
      exp_q0.push_back(item);
      due_q0.push_back(due);
    end else begin
      exp_q1.push_back(item);
      due_q1.push_back(due);
    end
  endtask

  // Apply one clock edge of the rules to instance d
  task automatic model_edge(input int d);
    logic        busy_pre;
    logic        byp;
    logic [15:0] val;
    logic [16:0] item;
    busy_pre = rem_m[d] > 0;
    if (!busy_pre) begin
      if (re) begin
        if (int'(raddr) >= depth_c[d]) begin
          item = '0;
        end else begin
          val = mem_m[d][raddr];
          byp = (rdw_c[d] == 1) && we && (waddr == raddr);
          if (byp) val = merge16(val, wdata, wbe);
          item = {corrupt_m[d][raddr] && !(byp && wbe[0]), val};
        end
        push_exp(d, item, cyc + lat_c[d] - 1);
      end
      if (we && int'(waddr) < depth_c[d]) begin
        mem_m[d][waddr] = merge16(mem_m[d][waddr], wdata, wbe);
        if (wbe[0]) corrupt_m[d][waddr] = 1'b0;
      end
      if (clr_req) rem_m[d] = depth_c[d];
    end else begin
      mem_m[d][depth_c[d] - rem_m[d]]     = fill_c[d];
      corrupt_m[d][depth_c[d] - rem_m[d]] = 1'b0;
      rem_m[d]--;
    end
  endtask

  always @(posedge clk) begin
    if (reset_n) begin
      cyc++;
      model_edge(0);
      model_edge(1);
    end
  end

  // Compare one instance's outputs against the model after an edge
  task automatic check_dut(input int d, input logic busy, input logic rv, input logic [15:0] rd,
                           input logic pe, input clr_state_t st);
    logic        exp_v;
    logic [16:0] item;
    string       n;
    n = (d == 0) ? "a" : "b";
    exp_v = 1'b0;
    item  = '0;
    if (d == 0) begin
      if (due_q0.size() > 0 && due_q0[0] == cyc) begin
        exp_v = 1'b1;
        item  = exp_q0.pop_front();
        void'(due_q0.pop_front());
      end
    end else begin
      if (due_q1.size() > 0 && due_q1[0] == cyc) begin
        exp_v = 1'b1;
        item  = exp_q1.pop_front();
        void'(due_q1.pop_front());
      end
    end
    if (exp_v) last_m[d] = item[15:0];
    check_eq({n, "_rvalid"}, 32'(rv), 32'(exp_v));
    check_eq({n, "_rdata"}, 32'(rd), 32'(last_m[d]));
    check_eq({n, "_perr"}, 32'(pe), 32'(exp_v & item[16]));
    check_eq({n, "_clr_busy"}, 32'(busy), 32'(rem_m[d] > 0));
    check_eq({n, "_state_clear"}, 32'(st == CLEAR), 32'(rem_m[d] > 0));
  endtask

  always @(negedge clk) begin
    if (reset_n && cyc > 0) begin
      check_dut(0, bus_a.clr_busy, bus_a.rvalid, bus_a.rdata, bus_a.perr, dbg_a);
      check_dut(1, bus_b.clr_busy, bus_b.rvalid, bus_b.rdata, bus_b.perr, dbg_b);
      if (bus_a.rvalid && bus_a.perr) perr_seen_a = 1'b1;
    end
  end

  // Driver tasks: inputs change 1 time unit after the falling edge
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_idle();
    we = 1'b0; re = 1'b0; clr_req = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    we = 1'b1; waddr = a; wdata = d; wbe = be;
    tick();
    we = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a);
    re = 1'b1; raddr = a;
    tick();
    re = 1'b0;
  endtask

  task automatic drain(input int n);
    set_idle();
    repeat (n) tick();
  endtask

  // Assert reset, reset the model, and check reset values at once
  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      rem_m[d]  = (cor_c[d] != 0) ? depth_c[d] : 0;
      last_m[d] = '0;
    end
    exp_q0.delete(); due_q0.delete();
    exp_q1.delete(); due_q1.delete();
    check_eq("a_rst_rvalid", 32'(bus_a.rvalid), 32'(0));
    check_eq("a_rst_rdata", 32'(bus_a.rdata), 32'(0));
    check_eq("a_rst_perr", 32'(bus_a.perr), 32'(0));
    check_eq("a_rst_busy", 32'(bus_a.clr_busy), 32'(1));
    check_eq("a_rst_state_clear", 32'(dbg_a == CLEAR), 32'(1));
    check_eq("b_rst_rvalid", 32'(bus_b.rvalid), 32'(0));
    check_eq("b_rst_rdata", 32'(bus_b.rdata), 32'(0));
    check_eq("b_rst_perr", 32'(bus_b.perr), 32'(0));
    check_eq("b_rst_busy", 32'(bus_b.clr_busy), 32'(0));
    check_eq("b_rst_state_clear", 32'(dbg_b == CLEAR), 32'(0));
  endtask

  // Count consecutive observed busy cycles of instance a, starting now
  task automatic measure_busy(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!bus_a.clr_busy) break;
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    checks = 0; failures = 0; cyc = 0; perr_seen_a = 1'b0;
    waddr = '0; raddr = '0; wdata = '0; wbe = '0;
    set_idle();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 16; a++) begin
        mem_m[d][a]     = 'x;
        corrupt_m[d][a] = 1'b0;
      end
    end
    reset_n = 1'b1;
    #2;
    apply_reset();
    tick(); tick();
    reset_n = 1'b1;

    // Sweep after reset release (a only)
    measure_busy(n);
    check_eq("reset_sweep_len", 32'(n), 32'(16));
    drain(2);

    // Requested sweep initialises both instances
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    measure_busy(n);
    check_eq("req_sweep_len", 32'(n), 32'(16));
    drain(2);

    // Read every address back-to-back: FILL, and zero for b's out-of-range words
    for (int a = 0; a < 16; a++) begin
      re = 1'b1; raddr = 4'(a);
      tick();
    end
    drain(4);
    check_eq("a_last_fill", 32'(bus_a.rdata), 32'(16'hA5A5));
    check_eq("b_oor_zero", 32'(bus_b.rdata), 32'(0));

    // Byte-enable merge
    do_write(4'd3, 16'h1234, 2'b11);
    do_write(4'd3, 16'hABCD, 2'b10);
    do_read(4'd3);
    drain(4);
    check_eq("a_be_merge", 32'(bus_a.rdata), 32'(16'hAB34));
    check_eq("b_be_merge", 32'(bus_b.rdata), 32'(16'hAB34));

    // Same-address read during write
    do_write(4'd5, 16'h0001, 2'b11);
    we = 1'b1; waddr = 4'd5; wdata = 16'h00FF; wbe = 2'b11;
    re = 1'b1; raddr = 4'd5;
    tick();
    drain(4);
    check_eq("a_rdw_read_first", 32'(bus_a.rdata), 32'(16'h0001));
    check_eq("b_rdw_write_first", 32'(bus_b.rdata), 32'(16'h00FF));

    // Sweep with an in-flight read, ignored traffic and a repeated request
    do_write(4'd7, 16'h7777, 2'b11);
    clr_req = 1'b1; re = 1'b1; raddr = 4'd3;
    tick();
    clr_req = 1'b0;
    we = 1'b1; waddr = 4'd7; wdata = 16'h1111; wbe = 2'b11;
    re = 1'b1; raddr = 4'd7;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!bus_a.clr_busy) break;
      n++;
      clr_req = (n == 5);
      tick();
    end
    set_idle();
    check_eq("clr_busy_len", 32'(n), 32'(16));
    drain(4);
    do_read(4'd7);
    drain(4);
    check_eq("a_clr_drop_write", 32'(bus_a.rdata), 32'(16'hA5A5));

    // Reset in the middle of a sweep
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (8) tick();
    apply_reset();
    tick(); tick();
    reset_n = 1'b1;
    measure_busy(n);
    check_eq("restart_sweep_len", 32'(n), 32'(16));
    drain(4);

    // Randomised traffic, including occasional clear requests
    for (int i = 0; i < 3000; i++) begin
      we      = 1'($urandom_range(0, 1));
      waddr   = 4'($urandom_range(0, 15));
      wdata   = 16'($urandom);
      wbe     = 2'($urandom_range(0, 3));
      re      = 1'($urandom_range(0, 1));
      raddr   = 4'($urandom_range(0, 15));
      clr_req = ($urandom_range(0, 199) == 0);
      tick();
    end
    drain(40);

`ifdef SDP_RAM_PARITY_EN
    // Flip one stored data bit in a: the read must flag a parity error
    u_a.u_array.g_lane[0].mem[2][0] = ~u_a.u_array.g_lane[0].mem[2][0];
    mem_m[0][2][0]  = ~mem_m[0][2][0];
    corrupt_m[0][2] = 1'b1;
    perr_seen_a = 1'b0;
    do_read(4'd2);
    drain(3);
    check_eq("a_perr_flip", 32'(perr_seen_a), 32'(1));
`endif

    check_eq("a_sb_empty", 32'(exp_q0.size()), 32'(0));
    check_eq("b_sb_empty", 32'(exp_q1.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdp_ram_ctrl.md
Name: sdp_ram_ctrl

Overview:
- Parametrised single-clock simple dual-port RAM for program/data memory of the brus16 system. Successor to the fixed 16-bit × 8K vendor-primitive wrapper.
- One write port with byte enables and one read port with a valid strobe.
- Selectable read latency and read-during-write policy.
- Built-in clear/fill sequencer that sweeps the whole array after reset or on request.
- The array is inferred, so it maps to block RAM on any target.

Parameters:
- DATA_W, 16, word width; must be a multiple of 8.
- DEPTH, 8192, number of words; need not be a power of two.
- ADDR_W, $clog2(DEPTH), address width; derived, do not override.
- READ_LAT, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register).
- RDW_MODE, 0, same-address read-during-write policy: 0 = read-first (old data), 1 = write-first (new merged data).
- CLEAR_ON_RESET, 1, 1 = run a full clear sweep automatically after reset release.
- FILL, 0, DATA_W-bit value written by the clear sweep.

Ports:
- clk, input, 1, single clock; all logic on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- clr_req, input, 1, single-cycle request to start a clear sweep.
- clr_busy, output, 1, high while the sweep runs.
- we, input, 1, write strobe.
- waddr, input, ADDR_W, write address.
- wdata, input, DATA_W, write data.
- wbe, input, DATA_W/8, byte enables; bit i gates wdata[8i+7:8i].
- re, input, 1, read strobe.
- raddr, input, ADDR_W, read address.
- rdata, output, DATA_W, read data.
- rvalid, output, 1, rdata valid qualifier.
- perr, output, 1, parity error flag, qualified by rvalid.

Behaviour:
- Reset values: rdata=0, rvalid=0, perr=0. clr_busy=CLEAR_ON_RESET, the sweep counter=0, and the FSM is in CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
- Reset does not touch the memory array contents.
- FSM states:
  - IDLE: clr_req=1 → CLEAR on the next edge, counter←0, clr_busy=1 from that cycle.
  - CLEAR: writes FILL with all bytes enabled to address counter, then counter++. After writing DEPTH-1, returns to IDLE and clr_busy falls on the following cycle. A full sweep takes exactly DEPTH busy cycles.
- While clr_busy=1:
  - User we and re are ignored; no rvalid is generated.
  - clr_req is ignored; the sweep is not restarted.
  - Reads already in flight when the sweep starts still complete with their data.
- Reset asserted mid-sweep aborts it immediately. After release, the sweep restarts from address 0 only if CLEAR_ON_RESET=1; otherwise partially cleared contents remain.
- Write: when we=1 and waddr<DEPTH, only the enabled bytes are updated at the edge. wbe=0 means no change. waddr≥DEPTH is dropped silently.
- Read: re sampled high at edge N produces rvalid=1 with rdata at edge N+READ_LAT. rvalid is a pulse per request, so back-to-back reads give one word per cycle. raddr≥DEPTH returns 0 with rvalid=1 and perr=0.
- When rvalid=0, rdata holds its last value.
- Same-address read and write in the same cycle:
  - RDW_MODE=0: return the pre-write word.
  - RDW_MODE=1: return the byte-merged new word (bypass mux).
  - Different addresses have no interaction.
- Address width: ADDR_W=$clog2(DEPTH); out-of-range detection compares against DEPTH, not 2^ADDR_W.

Optional Feature:
- Macro SDP_RAM_PARITY_EN.
- Defined:
  - Each byte stores an extra even-parity bit written alongside it; the clear sweep stores correct parity for FILL.
  - On read, parity is recomputed; perr=1 in the same cycle as rvalid if any byte mismatches.
  - Array width becomes DATA_W + DATA_W/8.
- Undefined: no parity storage; perr is tied to 0.

Decomposition:
- Package sdp_ram_pkg holds:
  - the clr_state_t enum (IDLE, CLEAR);
  - the RDW_READ_FIRST and RDW_WRITE_FIRST constants;
  - the function byte_merge(old, new, be);
  - the function byte_parity(word).
- One sub-module, sdp_ram_array: pure inferred storage with registered read and byte-enable write. The controller owns the FSM, bypass, latency pipe and parity check.

Test Plan:
- Clear after reset: DEPTH=16, FILL=16'hA5A5, release reset → clr_busy high exactly 16 cycles; then reading addresses 0..15 returns 16'hA5A5 on each.
- Byte-enable write: write 16'h1234 with wbe=2'b11 to address 3, then 16'hABCD with wbe=2'b10 → reading address 3 gives 16'hAB34, rvalid exactly READ_LAT cycles after re.
- Read-during-write: address 5 holds 16'h0001; same-cycle write of 16'h00FF and read of address 5 → returns 16'h0001 with RDW_MODE=0, 16'h00FF with RDW_MODE=1.
- Clear interaction: clr_req mid-stream with we=1 to address 7 and re=1 during the sweep → no rvalid and the write is dropped; address 7 reads FILL afterwards. A second clr_req during the sweep leaves the busy length at 16.
- Reset mid-sweep: assert reset_n=0 at sweep cycle 8 → outputs return to reset values immediately; sweep restarts at 0 after release and runs 16 cycles.
- Out of range and parity: DEPTH=12, read address 13 → 0 with rvalid=1. With SDP_RAM_PARITY_EN, force-flip one stored data bit → perr=1 alongside rvalid.
